colour_cmd_arbiter: RTL and testbench

Shares the `colour_manager` byte-command input between two requesters: the host UART receive stream and an on-chip preset player that replays a stored waveform/background colour pair. It sits between the UART receiver and `colour_manager`. It keeps every three-byte colour command (channel, intensity, component) atomic, so bytes from the two sources never interleave mid-command.

---
 rtl/colour_pkg.sv | 60 ++++++
 rtl/colour_preset_rom.sv | 55 +++++
 rtl/colour_cmd_arbiter.sv | 158 +++++++++++++++
 tb/tb_colour_cmd_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/colour_pkg.sv
// Shared constants, enums and grammar helpers for the colour command path.
package colour_pkg;

  localparam logic [7:0] ASCII_R  = 8'h72;
  localparam logic [7:0] ASCII_G  = 8'h67;
  localparam logic [7:0] ASCII_B  = 8'h62;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_BG = 8'h42;

  localparam int PRESET_LEN = 18;

  typedef enum logic [1:0] {
    ST_CHAN,
    ST_INT,
    ST_COMP
  } stage_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOCK,
    ARB_PLAY
  } arb_state_e;

  function automatic logic is_channel(input logic [7:0] c);
    return (c == ASCII_R) || (c == ASCII_G) || (c == ASCII_B);
  endfunction

  function automatic logic is_intensity(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_P);
  endfunction

  function automatic logic is_component(input logic [7:0] c);
    return (c == ASCII_W) || (c == ASCII_BG);
  endfunction

  function automatic logic [7:0] intensity_char(input logic [3:0] n);
    return ASCII_A + {4'h0, n};
  endfunction

  function automatic logic [11:0] preset_wave(input logic [1:0] sel);
    unique case (sel)
      2'd0:    return 12'hFFF;
      2'd1:    return 12'h0F0;
      2'd2:    return 12'hF00;
      default: return 12'h888;
    endcase
  endfunction

  function automatic logic [11:0] preset_bg(input logic [1:0] sel);
    unique case (sel)
      2'd0:    return 12'h000;
      2'd1:    return 12'h00F;
      2'd2:    return 12'h000;
      default: return 12'h111;
    endcase
  endfunction

endpackage

// File: rtl/colour_preset_rom.sv
// Maps (preset, byte index) to the command byte replayed for that preset.
module colour_preset_rom
  import colour_pkg::*;
(
  input  logic [1:0] sel_i,
  input  logic [4:0] idx_i,
  output logic [7:0] byte_o
);

  logic [2:0]  grp;
  logic [1:0]  pos;
  logic [1:0]  ch;
  logic        is_bg;
  logic [11:0] colour;
  logic [3:0]  nib;

  // Six 3-byte commands: R/G/B waveform, then R/G/B background
  always_comb begin
    grp = '0;
    pos = '0;
    for (int g = 0; g < 6; g++) begin
      if (int'(idx_i) >= 3 * g && int'(idx_i) < 3 * g + 3) begin
        grp = 3'(g);
        pos = 2'(int'(idx_i) - 3 * g);
      end
    end
  end

  assign is_bg  = (grp >= 3'd3);
  assign ch     = is_bg ? 2'(grp - 3'd3) : grp[1:0];
  assign colour = is_bg ? preset_bg(sel_i) : preset_wave(sel_i);

  always_comb begin
    unique case (ch)
      2'd0:    nib = colour[11:8];
      2'd1:    nib = colour[7:4];
      default: nib = colour[3:0];
    endcase
  end

  always_comb begin
    unique case (pos)
      2'd0: begin
        unique case (ch)
          2'd0:    byte_o = ASCII_R;
          2'd1:    byte_o = ASCII_G;
          default: byte_o = ASCII_B;
        endcase
      end
      2'd1:    byte_o = intensity_char(nib);
      default: byte_o = is_bg ? ASCII_BG : ASCII_W;
    endcase
  end

endmodule

// File: rtl/colour_cmd_arbiter.sv
// Arbitrates colour_manager byte input between UART and the preset player,
// keeping each three-byte command atomic.
module colour_cmd_arbiter
  import colour_pkg::*;
#(
  parameter int BYTE_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_data,
  input  logic       uart_data_valid,
  input  logic [1:0] preset_sel,
  input  logic       preset_go,
  output logic [7:0] cm_data,
  output logic       cm_data_valid,
  output logic       busy,
  output logic       preset_done,
  output logic       uart_drop
);

  localparam int GW = (BYTE_GAP < 1) ? 1 : $clog2(BYTE_GAP + 1);
  localparam logic [GW-1:0] GAP = GW'(BYTE_GAP);

  arb_state_e    state_q, state_d;
  stage_e        stage_q, stage_d;
  logic          pending_q, pending_d;
  logic [1:0]    sel_q, sel_d;
  logic [4:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    cm_data_q, cm_data_d;
  logic          cm_valid_q, cm_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;

  logic [1:0] rom_sel;
  logic [4:0] rom_idx;
  logic [7:0] rom_byte;

  // Byte 0 is read straight from preset_sel on the accept cycle
  assign rom_sel = (state_q == ARB_PLAY) ? sel_q : preset_sel;
  assign rom_idx = (state_q == ARB_PLAY) ? idx_q : 5'd0;

  colour_preset_rom u_rom (
    .sel_i  (rom_sel),
    .idx_i  (rom_idx),
    .byte_o (rom_byte)
  );

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    pending_d  = pending_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    cm_data_d  = cm_data_q;
    cm_valid_d = 1'b0;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (uart_data_valid) begin
          cm_valid_d = 1'b1;
          cm_data_d  = uart_data;
        end
        if (uart_data_valid && is_channel(uart_data)) begin
          state_d = ARB_LOCK;
          stage_d = ST_INT;
          if (preset_go) pending_d = 1'b1;
        end else if (preset_go || pending_q) begin
          state_d   = ARB_PLAY;
          sel_d     = preset_sel;
          pending_d = 1'b0;
          // A same-cycle UART byte owns the output; byte 0 goes next cycle
          if (uart_data_valid) begin
            idx_d = 5'd0;
            gap_d = '0;
          end else begin
            cm_valid_d = 1'b1;
            cm_data_d  = rom_byte;
            idx_d      = 5'd1;
            gap_d      = GAP;
          end
        end
      end
      ARB_LOCK: begin
        if (preset_go) pending_d = 1'b1;
        if (uart_data_valid) begin
          cm_valid_d = 1'b1;
          cm_data_d  = uart_data;
          unique case (stage_q)
            ST_CHAN: if (is_channel(uart_data)) stage_d = ST_INT;
            ST_INT:  if (is_intensity(uart_data)) stage_d = ST_COMP;
            default: begin
              if (is_component(uart_data)) begin
                stage_d = ST_CHAN;
                state_d = ARB_IDLE;
              end
            end
          endcase
        end
      end
      ARB_PLAY: begin
        drop_d = uart_data_valid;
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (idx_q == 5'(PRESET_LEN)) begin
          done_d  = 1'b1;
          state_d = ARB_IDLE;
          idx_d   = 5'd0;
        end else begin
          cm_valid_d = 1'b1;
          cm_data_d  = rom_byte;
          idx_d      = idx_q + 5'd1;
          gap_d      = (idx_q == 5'(PRESET_LEN - 1)) ? '0 : GAP;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE) || (state_q == ARB_LOCK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      stage_q    <= ST_CHAN;
      pending_q  <= 1'b0;
      sel_q      <= 2'd0;
      idx_q      <= 5'd0;
      gap_q      <= '0;
      cm_data_q  <= 8'h00;
      cm_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      pending_q  <= pending_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      cm_data_q  <= cm_data_d;
      cm_valid_q <= cm_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  assign cm_data       = cm_data_q;
  assign cm_data_valid = cm_valid_q;
  assign busy          = busy_q;
  assign preset_done   = done_q;
  assign uart_drop     = drop_q;

endmodule

// File: tb/tb_colour_cmd_arbiter.sv
// Directed bench for colour_cmd_arbiter with hand-written expected bytes.
module tb_colour_cmd_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] uart_data;
  logic       uart_data_valid;
  logic [1:0] preset_sel;
  logic       preset_go;
  logic [7:0] cm_data;
  logic       cm_data_valid;
  logic       busy;
  logic       preset_done;
  logic       uart_drop;

  int n_tests = 0;
  int n_fail  = 0;

  string PSEQ [4] = '{
    "rPWgPWbPWrABgABbAB",
    "rAWgPWbAWrABgABbPB",
    "rPWgAWbAWrABgABbAB",
    "rIWgIWbIWrBBgBBbBB"
  };

  colour_cmd_arbiter #(.BYTE_GAP(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .uart_data       (uart_data),
    .uart_data_valid (uart_data_valid),
    .preset_sel      (preset_sel),
    .preset_go       (preset_go),
    .cm_data         (cm_data),
    .cm_data_valid   (cm_data_valid),
    .busy            (busy),
    .preset_done     (preset_done),
    .uart_drop       (uart_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic uart_send(input logic [7:0] b);
    uart_data       = b;
    uart_data_valid = 1'b1;
    tick();
    uart_data_valid = 1'b0;
  endtask

  task automatic check_fwd(input string tag, input logic [7:0] b);
    check({tag, "_valid"}, 32'(cm_data_valid), 32'd1);
    check({tag, "_data"}, 32'(cm_data), 32'(b));
  endtask

  // Called when byte 0 should be on the output; drop_at injects a UART 'r'
  task automatic play_check(input int sel, input int drop_at);
    string s;
    int    c;
    logic  inj;
    s = PSEQ[sel];
    c = 0;
    for (int k = 0; k < 18; k++) begin
      check($sformatf("p%0d_b%0d_valid", sel, k), 32'(cm_data_valid), 32'd1);
      check($sformatf("p%0d_b%0d_data", sel, k), 32'(cm_data), 32'(s[k]));
      check($sformatf("p%0d_b%0d_busy", sel, k), 32'(busy), 32'd1);
      if (k < 17) begin
        for (int g = 0; g < 4; g++) begin
          inj = (c == drop_at);
          uart_data = 8'h72;
          uart_data_valid = inj;
          tick();
          uart_data_valid = 1'b0;
          c++;
          check($sformatf("p%0d_gap%0d_valid", sel, k), 32'(cm_data_valid), 32'd0);
          check($sformatf("p%0d_gap%0d_drop", sel, k), 32'(uart_drop), 32'(inj));
        end
        tick();
        c++;
      end
    end
    tick();
    check($sformatf("p%0d_done", sel), 32'(preset_done), 32'd1);
    check($sformatf("p%0d_done_busy", sel), 32'(busy), 32'd0);
    check($sformatf("p%0d_done_valid", sel), 32'(cm_data_valid), 32'd0);
    tick();
    check($sformatf("p%0d_done_pulse", sel), 32'(preset_done), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    uart_data = 8'h00;
    uart_data_valid = 1'b0;
    preset_sel = 2'd0;
    preset_go = 1'b0;
    tick();
    tick();
    check("rst_data", 32'(cm_data), 32'h00);
    check("rst_valid", 32'(cm_data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(preset_done), 32'd0);
    check("rst_drop", 32'(uart_drop), 32'd0);
    reset = 1'b0;
    tick();

    // UART r, A, B spaced five cycles apart
    uart_send(8'h72);
    check_fwd("u_r", 8'h72);
    check("u_r_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("u_gap_valid", 32'(cm_data_valid), 32'd0);
      check("u_gap_hold", 32'(cm_data), 32'h72);
      check("u_gap_busy", 32'(busy), 32'd1);
    end
    uart_send(8'h41);
    check_fwd("u_A", 8'h41);
    check("u_A_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    uart_send(8'h42);
    check_fwd("u_B", 8'h42);
    check("u_B_busy", 32'(busy), 32'd1);
    tick();
    check("u_end_busy", 32'(busy), 32'd0);
    check("u_end_valid", 32'(cm_data_valid), 32'd0);

    // Preset 1 from IDLE
    preset_sel = 2'd1;
    preset_go = 1'b1;
    tick();
    preset_go = 1'b0;
    play_check(1, -1);

    // Preset 0 with a UART byte dropped mid-play
    preset_sel = 2'd0;
    preset_go = 1'b1;
    tick();
    preset_go = 1'b0;
    play_check(0, 2);

    // preset_go during a UART command waits for the command to finish
    uart_send(8'h67);
    check_fwd("pend_g", 8'h67);
    preset_sel = 2'd3;
    preset_go = 1'b1;
    tick();
    preset_go = 1'b0;
    check("pend_go_valid", 32'(cm_data_valid), 32'd0);
    check("pend_go_busy", 32'(busy), 32'd1);
    uart_send(8'h43);
    check_fwd("pend_C", 8'h43);
    uart_send(8'h57);
    check_fwd("pend_W", 8'h57);
    check("pend_W_busy", 32'(busy), 32'd1);
    tick();
    play_check(3, -1);

    // Non-channel UART byte and preset_go in the same IDLE cycle
    preset_sel = 2'd2;
    uart_data = 8'h78;
    uart_data_valid = 1'b1;
    preset_go = 1'b1;
    tick();
    uart_data_valid = 1'b0;
    preset_go = 1'b0;
    check_fwd("same_x", 8'h78);
    check("same_x_busy", 32'(busy), 32'd1);
    tick();
    play_check(2, -1);

    // Reset in the middle of a preset
    preset_sel = 2'd0;
    preset_go = 1'b1;
    tick();
    preset_go = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_data", 32'(cm_data), 32'h00);
    check("mid_rst_valid", 32'(cm_data_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(preset_done), 32'd0);
    check("mid_rst_drop", 32'(uart_drop), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("post_rst_done", 32'(preset_done), 32'd0);
      check("post_rst_valid", 32'(cm_data_valid), 32'd0);
    end
    uart_send(8'h67);
    check_fwd("post_rst_g", 8'h67);
    check("post_rst_busy", 32'(busy), 32'd1);
    check("post_rst_drop", 32'(uart_drop), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
